// File: rtl/flu_wb_pkg.sv
// flu_wb_pkg: shared types and defaults for the writeback arbiter slice.
// Contents:
//   FLU_WB_NR_CH      default number of result channels
//   FLU_WB_DATA_W     result width held in each buffered entry
//   FLU_WB_TRANS_ID_W trans-ID width held in each buffered entry
//   FLU_WB_CAUSE_W    exception cause width
//   flu_wb_entry_t    one buffered result {result, trans_id, ex_valid, ex_cause}
package flu_wb_pkg;

  localparam int FLU_WB_NR_CH      = 4;
  localparam int FLU_WB_DATA_W     = 64;
  localparam int FLU_WB_TRANS_ID_W = 3;
  localparam int FLU_WB_CAUSE_W    = 64;

  // Entry fields are sized to the widest supported configuration; the top
  // zero-extends narrower results on the way in and truncates on the way out.
  typedef struct packed {
    logic [FLU_WB_DATA_W-1:0]     result;
    logic [FLU_WB_TRANS_ID_W-1:0] trans_id;
    logic                         ex_valid;
    logic [FLU_WB_CAUSE_W-1:0]    ex_cause;
  } flu_wb_entry_t;

endpackage

// File: rtl/flu_wb_fifo.sv
// flu_wb_fifo: single-channel result FIFO of flu_wb_entry_t.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empties the FIFO at the next edge (beats push/pop)
//   push_i, data_i  write request and entry; ignored while full
//   pop_i, data_o   read request and head entry; ignored while empty
//   full_o, empty_o status derived from the registered occupancy count
module flu_wb_fifo
  import flu_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  flu_wb_entry_t data_i,
  input  logic          pop_i,
  output flu_wb_entry_t data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  flu_wb_entry_t    mem_q [DEPTH];
  logic             do_push, do_pop;

  // Full is taken from the registered count, so a full FIFO refuses a push
  // even when it is being popped in the same cycle.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: merges NR_CH functional-unit result channels onto one
// registered scoreboard writeback port, with a small FIFO per channel.
// Build option: define FLU_WB_FIXED_PRIO_EN to give channel 0 absolute
// priority (channels 1..NR_CH-1 round-robin among themselves); undefined
// gives pure round-robin over all channels.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           drops all buffered results and the output register
//   ch_valid_i        per-channel result valid
//   ch_ready_o        per-channel FIFO not full
//   ch_result_i       packed results, channel k at [k*DATA_W +: DATA_W]
//   ch_trans_id_i     packed trans IDs
//   ch_ex_valid_i     per-channel exception flag
//   ch_ex_cause_i     packed 64-bit exception causes
//   wb_valid_o/ready_i  writeback handshake
//   wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o  writeback payload
//   wb_ch_o           channel that produced the current writeback
module flu_wb_arbiter
  import flu_wb_pkg::*;
#(
  parameter int NR_CH      = FLU_WB_NR_CH,
  parameter int DATA_W     = FLU_WB_DATA_W,
  parameter int TRANS_ID_W = FLU_WB_TRANS_ID_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NR_CH-1:0]            ch_valid_i,
  output logic [NR_CH-1:0]            ch_ready_o,
  input  logic [NR_CH*DATA_W-1:0]     ch_result_i,
  input  logic [NR_CH*TRANS_ID_W-1:0] ch_trans_id_i,
  input  logic [NR_CH-1:0]            ch_ex_valid_i,
  input  logic [NR_CH*64-1:0]         ch_ex_cause_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [DATA_W-1:0]           wb_result_o,
  output logic [TRANS_ID_W-1:0]       wb_trans_id_o,
  output logic                        wb_ex_valid_o,
  output logic [63:0]                 wb_ex_cause_o,
  output logic [$clog2(NR_CH)-1:0]    wb_ch_o
);

  localparam int CH_W = $clog2(NR_CH);

  flu_wb_entry_t    out_entry [NR_CH];
  flu_wb_entry_t    win_entry;
  logic [NR_CH-1:0] full, empty, pop;
  logic [CH_W-1:0]  rr_q, winner, cand;
  logic             grant, out_free, load;

  assign ch_ready_o = ~full;
  assign out_free   = ~wb_valid_o | wb_ready_i;
  assign load       = out_free & grant & ~flush_i;

  for (genvar k = 0; k < NR_CH; k++) begin : g_ch
    flu_wb_entry_t push_entry;

    assign push_entry.result   = FLU_WB_DATA_W'(ch_result_i[k*DATA_W +: DATA_W]);
    assign push_entry.trans_id = FLU_WB_TRANS_ID_W'(ch_trans_id_i[k*TRANS_ID_W +: TRANS_ID_W]);
    assign push_entry.ex_valid = ch_ex_valid_i[k];
    assign push_entry.ex_cause = ch_ex_cause_i[k*64 +: 64];
    assign pop[k]              = load & (winner == CH_W'(k));

    flu_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (ch_valid_i[k]),
      .data_i  (push_entry),
      .pop_i   (pop[k]),
      .data_o  (out_entry[k]),
      .full_o  (full[k]),
      .empty_o (empty[k])
    );
  end

  // Winner selection: scan non-empty FIFOs starting just after the last
  // granted channel. In fixed-priority builds channel 0 is checked first;
  // the scan itself is unchanged because it only reaches channel 0 when
  // that FIFO is empty.
  always_comb begin
    grant     = 1'b0;
    winner    = '0;
    cand      = '0;
    win_entry = '0;
`ifdef FLU_WB_FIXED_PRIO_EN
    if (!empty[0]) begin
      grant     = 1'b1;
      win_entry = out_entry[0];
    end
`endif
    for (int i = 1; i <= NR_CH; i++) begin
      cand = CH_W'((int'(rr_q) + i) % NR_CH);
      if (!grant && !empty[cand]) begin
        grant     = 1'b1;
        winner    = cand;
        win_entry = out_entry[cand];
      end
    end
  end

  // Output register: loads when free and a FIFO has data, drops valid when
  // free and nothing is waiting, and holds everything while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_result_o   <= '0;
      wb_trans_id_o <= '0;
      wb_ex_valid_o <= 1'b0;
      wb_ex_cause_o <= '0;
      wb_ch_o       <= '0;
      rr_q          <= CH_W'(NR_CH - 1);
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      rr_q       <= CH_W'(NR_CH - 1);
    end else if (out_free) begin
      if (grant) begin
        wb_valid_o    <= 1'b1;
        wb_result_o   <= DATA_W'(win_entry.result);
        wb_trans_id_o <= TRANS_ID_W'(win_entry.trans_id);
        wb_ex_valid_o <= win_entry.ex_valid;
        wb_ex_cause_o <= win_entry.ex_cause;
        wb_ch_o       <= winner;
`ifdef FLU_WB_FIXED_PRIO_EN
        if (winner != '0) rr_q <= winner;
`else
        rr_q <= winner;
`endif
      end else begin
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule
